rf_writeback_ctrl: RTL and testbench
====================================

// Module: rf_writeback_ctrl
// PURPOSE
//   Write-side controller for the 32x32 register file: it drives we/wa/wd.
//   Merges ALU results and late load returns into the single write port.
//   Load data is buffered in a small FIFO; ALU writes always take priority.
//   A per-register scoreboard tracks pending loads and raises a read hazard.
// PARAMETERS
//   XLEN   32  data width of register values
//   DEPTH  4   load-return FIFO entries (power of 2, >=2)
// PORTS
//   clk         in   1     clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   alu_valid   in   1     ALU result valid this cycle (no backpressure)
//   alu_rd      in   5     ALU destination register
//   alu_data    in   XLEN  ALU result
//   ld_valid    in   1     load return valid
//   ld_ready    out  1     load return accepted when ld_valid&ld_ready
//   ld_rd       in   5     load destination register
//   ld_data     in   XLEN  load data
//   iss_valid   in   1     load issued; mark iss_rd pending
//   iss_rd      in   5     destination of the issued load
//   iss_ready   out  1     issue accepted when iss_valid&iss_ready
//   chk_ra1     in   5     read address 1 to check (same as rf ra1)
//   chk_ra2     in   5     read address 2 to check (same as rf ra2)
//   hazard      out  1     a checked register is not yet readable; stall
//   rf_we       out  1     register-file write enable (registered)
//   rf_wa       out  5     register-file write address (registered)
//   rf_wd       out  XLEN  register-file write data (registered)
//   fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset: rf_we=0, rf_wa=0, rf_wd=0, FIFO empty (fifo_count=0), all busy bits 0.
//     Reset mid-operation discards FIFO contents and any pending write.
//   Write select, edge N (the result appears on rf_* during cycle N+1; 1-cycle latency):
//     - alu_valid && alu_rd!=0: write the ALU result. The FIFO does not pop.
//     - else if the FIFO is non-empty: pop the head and write it.
//     - else rf_we=0. rf_wa/rf_wd hold their last values.
//     - alu_valid with alu_rd==0 counts as no write. The FIFO may drain that cycle.
//   FIFO: ld_ready = (fifo_count < DEPTH), combinational from registered count.
//     - An accepted load with ld_rd==0 is dropped. It gets no entry and no write.
//     - Push and pop in the same cycle: count is unchanged and order is preserved.
//       Pointers wrap mod DEPTH.
//     - Continuous ALU writes may starve the FIFO. ld_ready then stays low. This is legal.
//   Scoreboard busy[31:1] (busy[0] is constant 0):
//     - iss_ready = !busy[iss_rd]. An accepted issue sets busy[iss_rd]. iss_rd==0 is a no-op.
//     - busy[r] clears on the edge at which a FIFO entry with rd=r pops.
//     - Set and clear on the same register in the same cycle: set wins, busy stays 1.
//   hazard (combinational), for each ra in {chk_ra1, chk_ra2}, ra!=0:
//     - busy[ra], or
//     - rf_we && rf_wa==ra (the write lands at the end of this cycle).
//   An ALU write to a busy register is a caller error. It is not checked, and
//     the later load write overwrites it.
//   Arithmetic: fifo_count saturates by construction. A push is never accepted when full.
// TESTING
//   1. ALU only: alu_valid=1, rd=5, data=0x1234 at edge N.
//      -> rf_we=1, wa=5, wd=0x1234 in cycle N+1. hazard=1 for chk_ra1=5 in N+1.
//   2. Load path: issue rd=7, then ld rd=7, data=0xDEAD with no ALU traffic.
//      -> busy[7]=1 (hazard=1) until the write. rf write 7/0xDEAD occurs 1 cycle after push.
//   3. Priority: ALU writes every cycle while 5 loads arrive.
//      -> 4 accepted, ld_ready=0, fifo_count=4.
//      -> When ALU stops, 4 writes follow in arrival order.
//   4. x0 rules: alu_rd=0, ld_rd=0, iss_rd=0.
//      -> No rf_we, busy unchanged, iss_ready=1, hazard=0 for ra=0.
//   5. Same-cycle clear+set: pop rd=3 while issue rd=3.
//      -> busy[3] remains 1. A second issue to 3 sees iss_ready=0.
//   6. Reset with 3 FIFO entries and busy[9]=1.
//      -> fifo_count=0, hazard=0, rf_we=0 immediately (asynchronous).

Source files
------------

// File: rtl/rf_writeback_ctrl_if.sv
// rf_writeback_ctrl_if: bundles the ALU, load-return, issue, hazard-check and register-file write signals.
//   master: the pipeline side; it drives the ALU results, load returns, issues and check addresses.
//   slave : the controller side; it drives ld_ready, iss_ready, hazard, rf_we/rf_wa/rf_wd and fifo_count.
interface rf_writeback_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                    alu_valid;
  logic [4:0]              alu_rd;
  logic [XLEN-1:0]         alu_data;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [4:0]              ld_rd;
  logic [XLEN-1:0]         ld_data;
  logic                    iss_valid;
  logic [4:0]              iss_rd;
  logic                    iss_ready;
  logic [4:0]              chk_ra1;
  logic [4:0]              chk_ra2;
  logic                    hazard;
  logic                    rf_we;
  logic [4:0]              rf_wa;
  logic [XLEN-1:0]         rf_wd;
  logic [$clog2(DEPTH):0]  fifo_count;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd, chk_ra1, chk_ra2,
    input  ld_ready, iss_ready, hazard, rf_we, rf_wa, rf_wd, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd, chk_ra1, chk_ra2,
    output ld_ready, iss_ready, hazard, rf_we, rf_wa, rf_wd, fifo_count
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges ALU results and buffered load returns into the single register-file write port and tracks pending loads.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rf_writeback_ctrl_if.slave (ALU/load/issue inputs, hazard check, registered rf write, FIFO occupancy)
module rf_writeback_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_writeback_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]      q_rd [DEPTH];
  logic [XLEN-1:0] q_d  [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic [31:0]     busy, busy_nxt;
  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;
  logic            alu_wr, push, pop, iss_acc, haz1, haz2;
  // ALU has priority; the FIFO only drains on cycles without a real ALU write.
  always_comb begin
    alu_wr   = bus.alu_valid && bus.alu_rd != 5'd0;
    pop      = !alu_wr && cnt != '0;
    push     = bus.ld_valid && bus.ld_ready && bus.ld_rd != 5'd0;
    iss_acc  = bus.iss_valid && bus.iss_ready && bus.iss_rd != 5'd0;
    busy_nxt = busy;
    if (pop) busy_nxt[q_rd[rp]] = 1'b0;
    // set is applied after clear so a same-cycle issue to the popping register keeps it busy
    if (iss_acc) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  // a register is unreadable while its load is pending or while its write is still in flight on the port
  always_comb begin
    haz1 = bus.chk_ra1 != 5'd0 && (busy[bus.chk_ra1] || (we_q && wa_q == bus.chk_ra1));
    haz2 = bus.chk_ra2 != 5'd0 && (busy[bus.chk_ra2] || (we_q && wa_q == bus.chk_ra2));
  end
  assign bus.hazard     = haz1 || haz2;
  assign bus.ld_ready   = cnt != (AW+1)'(DEPTH);
  assign bus.iss_ready  = !busy[bus.iss_rd];
  assign bus.fifo_count = cnt;
  assign bus.rf_we      = we_q;
  assign bus.rf_wa      = wa_q;
  assign bus.rf_wd      = wd_q;
  // storage needs no reset: the pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp] <= bus.ld_rd;
      q_d[wp]  <= bus.ld_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      busy <= '0;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      wp   <= wp + AW'(push);
      rp   <= rp + AW'(pop);
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      busy <= busy_nxt;
      we_q <= alu_wr || pop;
      if (alu_wr) begin
        wa_q <= bus.alu_rd;
        wd_q <= bus.alu_data;
      end else if (pop) begin
        wa_q <= q_rd[rp];
        wd_q <= q_d[rp];
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl: scoreboard bench for rf_writeback_ctrl with a reference model of the FIFO, busy bits and write port.
module tb_rf_writeback_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] d;} ent_t;
  typedef struct packed {logic we; logic [4:0] wa; logic [XLEN-1:0] wd;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t mq[$];
  wr_t exp_q[$];
  logic [31:0] mbusy = '0;
  logic mwe = 1'b0;
  logic [4:0] mwa = '0;
  always #5 clk = ~clk;
  rf_writeback_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();
  rf_writeback_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic mhaz(logic [4:0] ra);
    return ra != 5'd0 && (mbusy[ra] || (mwe && mwa == ra));
  endfunction
  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.iss_valid = 1'b0;
  endtask
  // checks combinational outputs, predicts the edge, advances one clock, then compares the write port
  task automatic cycle();
    wr_t w;
    ent_t e;
    logic alu_wr, ldr;
    logic [31:0] clr, set;
    #1;
    alu_wr = bus.alu_valid && bus.alu_rd != 5'd0;
    ldr = mq.size() < DEPTH;
    check("ld_ready", 64'(bus.ld_ready), 64'(ldr));
    check("iss_ready", 64'(bus.iss_ready), 64'(!mbusy[bus.iss_rd]));
    check("hazard", 64'(bus.hazard), 64'(mhaz(bus.chk_ra1) || mhaz(bus.chk_ra2)));
    clr = '0;
    set = '0;
    if (alu_wr) w = '{1'b1, bus.alu_rd, bus.alu_data};
    else if (mq.size() > 0) begin
      e = mq.pop_front();
      w = '{1'b1, e.rd, e.d};
      clr[e.rd] = 1'b1;
    end else w = '{1'b0, 5'd0, {XLEN{1'b0}}};
    if (bus.ld_valid && ldr && bus.ld_rd != 5'd0) mq.push_back('{bus.ld_rd, bus.ld_data});
    if (bus.iss_valid && !mbusy[bus.iss_rd] && bus.iss_rd != 5'd0) set[bus.iss_rd] = 1'b1;
    mbusy = ((mbusy & ~clr) | set) & ~32'h1;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("scoreboard_empty", 64'(0), 64'(1));
    else begin
      w = exp_q.pop_front();
      check("rf_we", 64'(bus.rf_we), 64'(w.we));
      if (w.we) begin
        check("rf_wa", 64'(bus.rf_wa), 64'(w.wa));
        check("rf_wd", 64'(bus.rf_wd), 64'(w.wd));
      end
      mwe = w.we;
      if (w.we) mwa = w.wa;
    end
    check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
  endtask
  task automatic idles(int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    idle();
    bus.alu_rd = '0; bus.alu_data = '0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.iss_rd = '0; bus.chk_ra1 = '0; bus.chk_ra2 = '0;
    #12;
    check("rst_rf_we", 64'(bus.rf_we), 64'(0));
    check("rst_rf_wa", 64'(bus.rf_wa), 64'(0));
    check("rst_rf_wd", 64'(bus.rf_wd), 64'(0));
    check("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    check("rst_ld_ready", 64'(bus.ld_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // ALU write, then hazard on the in-flight write address
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234; bus.chk_ra1 = 5'd5;
    cycle();
    check("t1_hazard", 64'(bus.hazard), 64'(1));
    idles(2);
    // issue, hazard while pending, load return, write
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.chk_ra1 = 5'd7;
    cycle();
    idle();
    check("t2_busy_hazard", 64'(bus.hazard), 64'(1));
    cycle();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'hDEAD;
    cycle();
    idles(3);
    check("t2_hazard_clear", 64'(bus.hazard), 64'(0));
    // ALU keeps the port busy while five loads arrive
    bus.chk_ra1 = 5'd0;
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'hA000 + 32'(i);
      bus.ld_valid = i < 5; bus.ld_rd = 5'(20 + i); bus.ld_data = 32'hB000 + 32'(i);
      cycle();
    end
    check("t3_full_count", 64'(bus.fifo_count), 64'(4));
    check("t3_full_ready", 64'(bus.ld_ready), 64'(0));
    idles(6);
    // x0 rules
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hEEEE;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.chk_ra1 = 5'd0; bus.chk_ra2 = 5'd0;
    cycle();
    cycle();
    idles(2);
    // same-cycle clear and set on register 3
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h3333;
    cycle();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; bus.chk_ra1 = 5'd3;
    cycle();
    check("t5_reissue_blocked", 64'(bus.iss_ready), 64'(0));
    cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'h3334;
    cycle();
    idles(3);
    // asynchronous reset with three queued loads and busy[9]
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.chk_ra1 = 5'd9;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'(i);
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(16 + i); bus.ld_data = 32'hC000 + 32'(i);
      cycle();
    end
    check("t6_pre_count", 64'(bus.fifo_count), 64'(3));
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count", 64'(bus.fifo_count), 64'(0));
    check("t6_hazard", 64'(bus.hazard), 64'(0));
    check("t6_rf_we", 64'(bus.rf_we), 64'(0));
    mq.delete(); exp_q.delete(); mbusy = '0; mwe = 1'b0; mwa = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idles(2);
    // random mix over a small register range
    for (int i = 0; i < 80; i++) begin
      bus.alu_valid = ($urandom_range(0, 9) < 4); bus.alu_rd = 5'($urandom_range(0, 7)); bus.alu_data = $urandom;
      bus.ld_valid = ($urandom_range(0, 9) < 5); bus.ld_rd = 5'($urandom_range(0, 7)); bus.ld_data = $urandom;
      bus.iss_valid = ($urandom_range(0, 9) < 3); bus.iss_rd = 5'($urandom_range(0, 7));
      bus.chk_ra1 = 5'($urandom_range(0, 7)); bus.chk_ra2 = 5'($urandom_range(0, 7));
      cycle();
    end
    idles(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
